cape_pin_owner_ctrl: RTL and testbench

APB-configured ownership controller for the 28 cape GPIO pads driven through the P8 pad block. Each pad is owned either by the MSS GPIO controller or by a fabric requester, for example a soft core's blink output. Ownership changes are sequenced so that a switching pad is tri-stated for a programmable turnaround time before the new owner drives it. The block sits between the MSS GPIO/fabric sources and the P8 pad GPIO_OE/GPIO_OUT bus, on the cape APB slave.

---
 rtl/cape_pin_owner_ctrl.sv | 151 +++++++++++++++
 tb/tb_cape_pin_owner_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cape_pin_owner_ctrl.sv
// Cape pad ownership controller.
//
// Arbitrates the NPINS cape GPIO pads between the MSS GPIO controller and a
// fabric requester. An ownership change first tri-states the switching pads for
// TURNAROUND+2 cycles, then hands them to the new owner. Configured over APB.
//
// Ports
//   PCLK, PRESETN        clock, synchronous active-low reset
//   PSEL..PRDATA         APB slave, zero wait states, PRDATA decoded from PADDR
//   MSS_OE, MSS_OUT      MSS GPIO drive request
//   FAB_OE, FAB_OUT      fabric drive request
//   PAD_IN               pad input from the pad block
//   PAD_OE, PAD_OUT      registered drive to the pad block
//   PIN_IN               PAD_IN passthrough to both owners
//   BUSY                 ownership switch in progress
//   IRQ                  DONE & IRQ_EN
module cape_pin_owner_ctrl #(
   parameter int unsigned NPINS    = 28,
   parameter logic [7:0]  TURN_RST = 8'd4
) (
   input  logic             PCLK,
   input  logic             PRESETN,
   input  logic             PSEL,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [7:0]       PADDR,
   input  logic [31:0]      PWDATA,
   output logic [31:0]      PRDATA,
   input  logic [NPINS-1:0] MSS_OE,
   input  logic [NPINS-1:0] MSS_OUT,
   input  logic [NPINS-1:0] FAB_OE,
   input  logic [NPINS-1:0] FAB_OUT,
   input  logic [NPINS-1:0] PAD_IN,
   output logic [NPINS-1:0] PAD_OE,
   output logic [NPINS-1:0] PAD_OUT,
   output logic [NPINS-1:0] PIN_IN,
   output logic             BUSY,
   output logic             IRQ
);

   localparam logic [5:0] AddrOwnerReq = 6'h00;
   localparam logic [5:0] AddrOwnerAct = 6'h01;
   localparam logic [5:0] AddrTurn     = 6'h02;
   localparam logic [5:0] AddrStatus   = 6'h03;
   localparam logic [5:0] AddrPadSync  = 6'h04;

   typedef enum logic [1:0] {StIdle, StQuiesce, StCommit} state_e;

   state_e           state_q;
   logic [NPINS-1:0] owner_req_q;
   logic [NPINS-1:0] owner_act_q;
   logic [NPINS-1:0] mask_q;
   logic [NPINS-1:0] target_q;
   logic [7:0]       cnt_q;
   logic [7:0]       turn_q;
   logic             done_q;
   logic             irq_en_q;
   logic [NPINS-1:0] sync1_q;
   logic [NPINS-1:0] sync2_q;
   logic [NPINS-1:0] pad_oe_q;
   logic [NPINS-1:0] pad_out_q;

   logic             wr;
   logic [5:0]       addr;
   logic [NPINS-1:0] drive_mask;
   logic [NPINS-1:0] pad_oe_d;
   logic [NPINS-1:0] pad_out_d;

   assign wr   = PSEL & PENABLE & PWRITE;
   assign addr = PADDR[7:2];

   // Switching pads are held off for the whole QUIESCE/COMMIT window; every
   // other pad keeps following whichever owner is currently active.
   always_comb begin
      drive_mask = (state_q != StIdle) ? mask_q : '0;
      pad_oe_d   = ((owner_act_q & FAB_OE)  | (~owner_act_q & MSS_OE))  & ~drive_mask;
      pad_out_d  = ((owner_act_q & FAB_OUT) | (~owner_act_q & MSS_OUT)) & ~drive_mask;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         state_q     <= StIdle;
         owner_req_q <= '0;
         owner_act_q <= '0;
         mask_q      <= '0;
         target_q    <= '0;
         cnt_q       <= '0;
         turn_q      <= TURN_RST;
         done_q      <= 1'b0;
         irq_en_q    <= 1'b0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         pad_oe_q    <= '0;
         pad_out_q   <= '0;
      end else begin
         sync1_q   <= PAD_IN;
         sync2_q   <= sync1_q;
         pad_oe_q  <= pad_oe_d;
         pad_out_q <= pad_out_d;

         if (wr && addr == AddrOwnerReq) owner_req_q <= PWDATA[NPINS-1:0];
         if (wr && addr == AddrTurn)     turn_q      <= PWDATA[7:0];
         if (wr && addr == AddrStatus) begin
            irq_en_q <= PWDATA[8];
            if (PWDATA[1]) done_q <= 1'b0;
         end

         // The COMMIT branch comes after the W1C above so a coincident set wins.
         case (state_q)
            StIdle: begin
               if (owner_req_q != owner_act_q) begin
                  mask_q   <= owner_req_q ^ owner_act_q;
                  target_q <= owner_req_q;
                  cnt_q    <= turn_q;
                  state_q  <= StQuiesce;
               end
            end
            StQuiesce: begin
               if (cnt_q == 8'd0) state_q <= StCommit;
               else               cnt_q   <= cnt_q - 8'd1;
            end
            StCommit: begin
               owner_act_q <= target_q;
               done_q      <= 1'b1;
               mask_q      <= '0;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      PRDATA = '0;
      case (addr)
         AddrOwnerReq: PRDATA = 32'(owner_req_q);
         AddrOwnerAct: PRDATA = 32'(owner_act_q);
         AddrTurn:     PRDATA = {24'd0, turn_q};
         AddrStatus:   PRDATA = {23'd0, irq_en_q, 6'd0, done_q, BUSY};
         AddrPadSync:  PRDATA = 32'(sync2_q);
         default:      PRDATA = '0;
      endcase
   end

   assign BUSY    = (state_q != StIdle);
   assign IRQ     = done_q & irq_en_q;
   assign PAD_OE  = pad_oe_q;
   assign PAD_OUT = pad_out_q;
   assign PIN_IN  = PAD_IN;

endmodule

// File: tb/tb_cape_pin_owner_ctrl.sv
module tb_cape_pin_owner_ctrl;

   localparam int N = 28;

   logic          PCLK = 1'b0;
   logic          PRESETN;
   logic          PSEL, PENABLE, PWRITE;
   logic [7:0]    PADDR;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA;
   logic [N-1:0]  MSS_OE, MSS_OUT, FAB_OE, FAB_OUT, PAD_IN;
   logic [N-1:0]  PAD_OE, PAD_OUT, PIN_IN;
   logic          BUSY, IRQ;

   int n_checks = 0;
   int n_fail   = 0;

   cape_pin_owner_ctrl #(.NPINS(N), .TURN_RST(8'd4)) dut (
      .PCLK    (PCLK),
      .PRESETN (PRESETN),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .MSS_OE  (MSS_OE),
      .MSS_OUT (MSS_OUT),
      .FAB_OE  (FAB_OE),
      .FAB_OUT (FAB_OUT),
      .PAD_IN  (PAD_IN),
      .PAD_OE  (PAD_OE),
      .PAD_OUT (PAD_OUT),
      .PIN_IN  (PIN_IN),
      .BUSY    (BUSY),
      .IRQ     (IRQ)
   );

   always #5 PCLK = ~PCLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      PADDR = a;
      #1;
      check_eq(tag, PRDATA, exp);
   endtask

   // Write edge T happened just before the call; k counts negedges after T.
   task automatic watch(input int ta, input logic [N-1:0] msk, input logic [N-1:0] old_act,
                        input logic [N-1:0] new_act, input int ncyc);
      logic [N-1:0] act, m, e_oe, e_out;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge PCLK);
         #1;
         act   = (k >= ta + 4) ? new_act : old_act;
         m     = (k >= 2 && k <= ta + 3) ? msk : '0;
         e_oe  = ((act & FAB_OE)  | (~act & MSS_OE))  & ~m;
         e_out = ((act & FAB_OUT) | (~act & MSS_OUT)) & ~m;
         check_eq($sformatf("ta%0d k%0d pad_oe", ta, k),  32'(PAD_OE),  32'(e_oe));
         check_eq($sformatf("ta%0d k%0d pad_out", ta, k), 32'(PAD_OUT), 32'(e_out));
         check_eq($sformatf("ta%0d k%0d busy", ta, k),    32'(BUSY),
                  32'((k >= 1 && k <= ta + 2) ? 1 : 0));
      end
   endtask

   initial begin
      PRESETN = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = '0;
      MSS_OE = '1; MSS_OUT = '0; FAB_OE = '0; FAB_OUT = '0; PAD_IN = '0;

      // Reset
      repeat (2) @(negedge PCLK);
      check_eq("rst pad_oe", 32'(PAD_OE), 32'h0);
      rd_chk("rst owner_act", 8'h04, 32'h0);
      rd_chk("rst owner_req", 8'h00, 32'h0);
      rd_chk("rst turn", 8'h08, 32'h4);
      rd_chk("rst status", 8'h0C, 32'h0);
      check_eq("rst irq", 32'(IRQ), 32'h0);
      PRESETN = 1'b1;
      @(negedge PCLK);
      #1;
      check_eq("post rst pad_oe", 32'(PAD_OE), 32'h0FFF_FFFF);

      // Input passthrough and synchroniser
      PAD_IN = 28'h123_4567;
      #1;
      check_eq("pin_in", 32'(PIN_IN), 32'h0123_4567);
      @(negedge PCLK);
      rd_chk("pad_sync 1cyc", 8'h10, 32'h0);
      @(negedge PCLK);
      rd_chk("pad_sync 2cyc", 8'h10, 32'h0123_4567);

      // Single switch of pins 5,6 with TURNAROUND=4
      MSS_OE = 28'hFFF_FF9C; MSS_OUT = 28'hAAA_AAAA;
      FAB_OE = 28'h000_0063; FAB_OUT = 28'h000_0021;
      apb_write(8'h00, 32'h60);
      watch(4, 28'h60, 28'h0, 28'h60, 9);
      check_eq("sw oe[6:5]", 32'(PAD_OE[6:5]), 32'h3);
      check_eq("sw out[6:5]", 32'(PAD_OUT[6:5]), 32'h1);
      rd_chk("sw owner_act", 8'h04, 32'h60);
      rd_chk("sw status", 8'h0C, 32'h2);
      apb_write(8'h0C, 32'h2);
      rd_chk("w1c status", 8'h0C, 32'h0);

      // TURNAROUND=0, switch pin 0
      apb_write(8'h08, 32'h0);
      rd_chk("turn 0", 8'h08, 32'h0);
      apb_write(8'h00, 32'h61);
      watch(0, 28'h1, 28'h60, 28'h61, 5);
      rd_chk("ta0 owner_act", 8'h04, 32'h61);

      // IRQ, and set-wins when W1C lands on the COMMIT edge
      apb_write(8'h0C, 32'h102);
      rd_chk("irq_en status", 8'h0C, 32'h100);
      check_eq("irq low", 32'(IRQ), 32'h0);
      apb_write(8'h00, 32'h60);
      repeat (3) @(negedge PCLK);
      #1;
      check_eq("irq high", 32'(IRQ), 32'h1);
      rd_chk("irq status", 8'h0C, 32'h102);
      apb_write(8'h00, 32'h61);
      apb_write(8'h0C, 32'h102);
      rd_chk("set wins status", 8'h0C, 32'h102);
      check_eq("set wins irq", 32'(IRQ), 32'h1);
      rd_chk("set wins act", 8'h04, 32'h61);
      apb_write(8'h0C, 32'h102);
      rd_chk("clr status", 8'h0C, 32'h100);
      check_eq("clr irq", 32'(IRQ), 32'h0);

      // Reset in the middle of QUIESCE
      apb_write(8'h08, 32'h4);
      apb_write(8'h00, 32'h3);
      @(negedge PCLK);
      @(negedge PCLK);
      #1;
      check_eq("pre rst busy", 32'(BUSY), 32'h1);
      PRESETN = 1'b0;
      @(negedge PCLK);
      PRESETN = 1'b1;
      #1;
      check_eq("mid rst busy", 32'(BUSY), 32'h0);
      check_eq("mid rst pad_oe", 32'(PAD_OE), 32'h0);
      check_eq("mid rst pad_out", 32'(PAD_OUT), 32'h0);
      check_eq("mid rst irq", 32'(IRQ), 32'h0);
      rd_chk("mid rst req", 8'h00, 32'h0);
      rd_chk("mid rst act", 8'h04, 32'h0);
      rd_chk("mid rst status", 8'h0C, 32'h0);
      @(negedge PCLK);
      #1;
      check_eq("after rst pad_oe", 32'(PAD_OE), 32'(MSS_OE));
      repeat (3) @(negedge PCLK);
      rd_chk("after rst status", 8'h0C, 32'h0);

      // Mid-sequence OWNER_REQ write
      apb_write(8'h00, 32'h1);
      apb_write(8'h00, 32'h3);
      repeat (4) @(negedge PCLK);
      rd_chk("mid first act", 8'h04, 32'h1);
      rd_chk("mid first status", 8'h0C, 32'h2);
      watch(4, 28'h2, 28'h1, 28'h3, 9);
      rd_chk("mid second act", 8'h04, 32'h3);

      rd_chk("unmapped", 8'h14, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
